// File: rtl/df_pkg.sv
// df_pkg: encodings shared by the filter core, the configuration controller and the top.
// Rev 1.0 - initial release.
`default_nettype none

package df_pkg;

  typedef enum logic [1:0] {
    ST_FLUSH  = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } df_state_e;

  localparam logic [1:0] WG_0125 = 2'b00;
  localparam logic [1:0] WG_0375 = 2'b01;
  localparam logic [1:0] WG_0625 = 2'b10;
  localparam logic [1:0] WG_0875 = 2'b11;

  localparam logic FLT_LP = 1'b0;
  localparam logic FLT_HP = 1'b1;

  localparam int UIO_EN  = 3;
  localparam int UIO_HP  = 2;
  localparam int UIO_WG1 = 1;
  localparam int UIO_WG0 = 0;

endpackage

`default_nettype wire

// File: rtl/df_cfg_ctrl_if.sv
// df_cfg_ctrl_if: uio-side configuration inputs and filter-core control outputs of df_cfg_ctrl.
// Rev 1.0 - initial release.
`default_nettype none

interface df_cfg_ctrl_if;
  logic       ena;
  logic       cfg_en_i;
  logic       cfg_hp_i;
  logic [1:0] cfg_wg_i;
  logic       sample_tick_i;
  logic       hp_o;
  logic [1:0] wg_o;
  logic       flt_clr_o;
  logic       flt_run_o;
  logic       out_valid_o;
  logic       busy_o;

  modport master (
    output ena, cfg_en_i, cfg_hp_i, cfg_wg_i, sample_tick_i,
    input  hp_o, wg_o, flt_clr_o, flt_run_o, out_valid_o, busy_o
  );

  modport slave (
    input  ena, cfg_en_i, cfg_hp_i, cfg_wg_i, sample_tick_i,
    output hp_o, wg_o, flt_clr_o, flt_run_o, out_valid_o, busy_o
  );
endinterface

`default_nettype wire

// File: rtl/df_sync2.sv
// df_sync2: WIDTH-bit two-flop synchroniser, asynchronous active-low reset to zero.
// Rev 1.0 - initial release.
`default_nettype none

module df_sync2 #(
  parameter int WIDTH = 4
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic [WIDTH-1:0] din,
  output logic      [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= din;
      r_s2 <= r_s1;
    end
  end

  assign dout = r_s2;

endmodule

`default_nettype wire

// File: rtl/df_cfg_ctrl.sv
// df_cfg_ctrl: synchronises the uio config strobe, flushes and settles the filter, gates its update enable.
// Rev 1.0 - initial release.
`default_nettype none

module df_cfg_ctrl
  import df_pkg::*;
#(
  parameter int FLUSH_CYCLES   = 2,
  parameter int SETTLE_SAMPLES = 8,
  parameter int CNT_W          = 8
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  df_cfg_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] C_FLUSH  = CNT_W'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] C_SETTLE = CNT_W'(SETTLE_SAMPLES);
  localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);

  logic [3:0]       w_cfg_raw;
  logic [3:0]       w_cfg_sync;
  logic             r_en_d;
  logic             w_req;

  df_state_e        r_state;
  df_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_hp;
  logic             w_hp_nxt;
  logic [1:0]       r_wg;
  logic [1:0]       w_wg_nxt;

  assign w_cfg_raw[UIO_EN]  = bus.cfg_en_i;
  assign w_cfg_raw[UIO_HP]  = bus.cfg_hp_i;
  assign w_cfg_raw[UIO_WG1] = bus.cfg_wg_i[1];
  assign w_cfg_raw[UIO_WG0] = bus.cfg_wg_i[0];

  df_sync2 #(.WIDTH(4)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (w_cfg_raw),
    .dout (w_cfg_sync)
  );

  // Edge history keeps running while ena=0 so a strobe seen then is consumed, not deferred.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_en_d <= 1'b0;
    else        r_en_d <= w_cfg_sync[UIO_EN];
  end

  assign w_req = w_cfg_sync[UIO_EN] & ~r_en_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_FLUSH;
      r_cnt   <= C_FLUSH;
      r_hp    <= FLT_LP;
      r_wg    <= WG_0125;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_hp    <= w_hp_nxt;
      r_wg    <= w_wg_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hp_nxt    = r_hp;
    w_wg_nxt    = r_wg;
    if (bus.ena) begin
      if (w_req) begin
        w_state_nxt = ST_FLUSH;
        w_cnt_nxt   = C_FLUSH;
        w_hp_nxt    = w_cfg_sync[UIO_HP];
        w_wg_nxt    = {w_cfg_sync[UIO_WG1], w_cfg_sync[UIO_WG0]};
      end else begin
        unique case (r_state)
          ST_FLUSH: begin
            // <= rather than == so a zero count can never wrap.
            if (r_cnt <= C_ONE) begin
              w_state_nxt = (SETTLE_SAMPLES == 0) ? ST_RUN : ST_SETTLE;
              w_cnt_nxt   = C_SETTLE;
            end else begin
              w_cnt_nxt   = r_cnt - C_ONE;
            end
          end
          ST_SETTLE: begin
            if (bus.sample_tick_i) begin
              if (r_cnt <= C_ONE) w_state_nxt = ST_RUN;
              else                w_cnt_nxt   = r_cnt - C_ONE;
            end
          end
          ST_RUN: begin
            w_state_nxt = ST_RUN;
          end
          default: begin
            w_state_nxt = ST_FLUSH;
            w_cnt_nxt   = C_FLUSH;
          end
        endcase
      end
    end
  end

  assign bus.hp_o        = r_hp;
  assign bus.wg_o        = r_wg;
  assign bus.flt_clr_o   = bus.ena & (r_state == ST_FLUSH);
  assign bus.flt_run_o   = bus.ena & (r_state != ST_FLUSH) & bus.sample_tick_i;
  assign bus.out_valid_o = (r_state == ST_RUN);
  assign bus.busy_o      = (r_state != ST_RUN);

endmodule

`default_nettype wire
